// File: rtl/row_window_sum_pkg.sv
// Shared constants and elaboration helpers for the vertical window summer.
package row_window_sum_pkg;

    localparam int WIN_MIN = 2;
    localparam int WIN_MAX = 4;

    // Ceiling log2; returns the bit count needed to index v entries.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Narrowest sum width that can hold WIN full-scale samples.
    function automatic int min_sum_w(input int data_w, input int win);
        return data_w + clog2(win);
    endfunction

    // Window depth supported by the line-buffer chain.
    function automatic bit win_legal(input int win);
        return (win >= WIN_MIN) && (win <= WIN_MAX);
    endfunction

endpackage

// File: rtl/row_window_sum_line_fifo.sv
// Show-ahead line FIFO: dout always presents the oldest word while non-empty.
// Storage is an array with a registered read port; a write into the slot that
// becomes the head is forwarded straight to dout.
module line_fifo
    import row_window_sum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and level bookkeeping; clr empties the FIFO regardless of traffic.
    always_comb begin
        wr_ptr_next = wr_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = rd_en ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg + CW'(wr_en) - CW'(rd_en);
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Registered read of the next head, forwarding a same-cycle write into it.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= din;
        end else begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

    assign dout  = dout_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/row_window_sum.sv
// Streaming vertical-window adder: sums each column over the last WIN rows
// of a ROW_NUM x COL_NUM raster using a chain of WIN-1 line FIFOs.
module row_window_sum
    import row_window_sum_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COL_NUM = 10,
    parameter int ROW_NUM = 10,
    parameter int WIN     = 3,
    parameter int SUM_W   = DATA_W + 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_flag,
    input  logic              frame_clr,
    output logic [SUM_W-1:0]  po_sum,
    output logic              po_flag,
    output logic              po_last,
    output logic              frame_done
);
    localparam int NB = WIN - 1;
    localparam int CW = clog2(COL_NUM);
    localparam int RW = clog2(ROW_NUM);

    if (!win_legal(WIN)) begin : g_bad_win
        $error("row_window_sum: WIN out of range");
    end
    if (SUM_W < min_sum_w(DATA_W, WIN)) begin : g_bad_sum_w
        $error("row_window_sum: SUM_W too narrow");
    end

    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic              take;
    logic              last_sample;
    logic              fifo_clr;
    logic              valid_next;
    logic [SUM_W-1:0]  sum_next;
    logic [SUM_W-1:0]  po_sum_reg;
    logic              po_flag_reg, po_last_reg, frame_done_reg;

    logic [DATA_W-1:0] fifo_din  [NB];
    logic [DATA_W-1:0] fifo_dout [NB];
    logic [NB-1:0]     wr_req, wr_en, rd_en, full, empty;

    // Sample acceptance, frame-end detection and buffer flush requests.
    always_comb begin
        take        = pi_flag && !frame_clr;
        last_sample = take && (col_reg == CW'(COL_NUM - 1))
                           && (row_reg == RW'(ROW_NUM - 1));
        fifo_clr    = frame_clr || last_sample;
        valid_next  = take && (row_reg >= RW'(WIN - 1));
    end

    // Line buffer chain: buf[k] holds row r-1-k and feeds buf[k+1].
    genvar gi;
    for (gi = 0; gi < NB; gi++) begin : g_buf
        if (gi == 0) begin : g_head
            assign wr_req[gi]   = take;
            assign fifo_din[gi] = pi_data;
        end else begin : g_tail
            assign wr_req[gi]   = rd_en[gi-1];
            assign fifo_din[gi] = fifo_dout[gi-1];
        end
        assign rd_en[gi] = take && (row_reg >= RW'(gi + 1)) && !empty[gi];
        assign wr_en[gi] = wr_req[gi] && (!full[gi] || rd_en[gi]);

        line_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (COL_NUM)
        ) u_fifo (
            .clk   (sys_clk),
            .rst   (sys_rst),
            .clr   (fifo_clr),
            .wr_en (wr_en[gi]),
            .din   (fifo_din[gi]),
            .rd_en (rd_en[gi]),
            .dout  (fifo_dout[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    // Column sum of the incoming sample and all buffer heads.
    always_comb begin
        sum_next = SUM_W'(pi_data);
        for (int k = 0; k < NB; k++) begin
            sum_next = sum_next + SUM_W'(fifo_dout[k]);
        end
    end

    // Raster position counters, column-fastest, wrapping at frame end.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (frame_clr) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (pi_flag) begin
            if (col_reg == CW'(COL_NUM - 1)) begin
                col_reg <= '0;
                row_reg <= (row_reg == RW'(ROW_NUM - 1)) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Registered outputs; po_sum holds between results.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            po_sum_reg     <= '0;
            po_flag_reg    <= 1'b0;
            po_last_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            po_flag_reg    <= valid_next;
            po_last_reg    <= last_sample;
            frame_done_reg <= last_sample;
            if (valid_next) begin
                po_sum_reg <= sum_next;
            end
        end
    end

    assign po_sum     = po_sum_reg;
    assign po_flag    = po_flag_reg;
    assign po_last    = po_last_reg;
    assign frame_done = frame_done_reg;

endmodule
